// File: rtl/stu_pkg.sv
// Shared types and constants for the STU core cluster front end.
package stu_pkg;

  localparam int unsigned NUM_CORES  = 4;
  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned CORE_ID_W  = $clog2(NUM_CORES);
  localparam int unsigned PERF_W     = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CORE_ID_W-1:0]  core_id_t;
  typedef logic [NUM_CORES-1:0]  core_mask_t;

  // Speculation level carried by a code-block descriptor
  typedef enum logic [1:0] {
    SPEC_LEVEL_0        = 2'b00,
    SPEC_LEVEL_1        = 2'b01,
    SPEC_LEVEL_2        = 2'b10,
    SPEC_LEVEL_0_BYPASS = 2'b11
  } spec_level_t;

  // Dispatcher scheduling state
  typedef enum logic [1:0] {
    DISP_RUN    = 2'd0,
    DISP_DRAIN  = 2'd1,
    DISP_SERIAL = 2'd2,
    DISP_FLUSH  = 2'd3
  } dispatch_state_t;

  // Levels that must run alone on an otherwise idle cluster
  function automatic logic is_serial_level(input spec_level_t lvl);
    return (lvl == SPEC_LEVEL_0) || (lvl == SPEC_LEVEL_0_BYPASS);
  endfunction

endpackage

// File: rtl/stu_rr_picker.sv
// Round-robin free-core picker: first free core at or after rr_ptr_i, with wrap.
module stu_rr_picker
  import stu_pkg::*;
(
  input  logic [NUM_CORES-1:0] free_i,
  input  logic [CORE_ID_W-1:0] rr_ptr_i,
  output logic [NUM_CORES-1:0] grant_o,
  output logic [CORE_ID_W-1:0] grant_idx_o,
  output logic                 any_free_o
);

  core_id_t cand;
  logic     found;

  // Scan cores starting at the pointer; NUM_CORES is a power of two so the index wraps naturally
  always_comb begin
    grant_o     = '0;
    grant_idx_o = rr_ptr_i;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = core_id_t'(rr_ptr_i + core_id_t'(i));
      if (!found && free_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  assign any_free_o = |free_i;

endmodule

// File: rtl/stu_block_dispatcher.sv
// Speculative code-block dispatcher for the STU core cluster.
// Level 0 blocks run alone, levels 1/2 run in parallel, a level-2
// misspeculation squashes every in-flight level-2 block.
// Optional build macro STU_DISPATCH_PERF_EN adds saturating perf counters.
module stu_block_dispatcher
  import stu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [ADDR_WIDTH-1:0] blk_pc_i,
  input  logic [1:0]            blk_level_i,
  output logic [NUM_CORES-1:0]  disp_valid_o,
  output logic [ADDR_WIDTH-1:0] disp_pc_o,
  output logic [1:0]            disp_level_o,
  input  logic [NUM_CORES-1:0]  core_done_i,
  input  logic [NUM_CORES-1:0]  spec_fail_i,
  output logic [NUM_CORES-1:0]  flush_o,
  output logic [NUM_CORES-1:0]  busy_o,
  output logic [1:0]            state_o
`ifdef STU_DISPATCH_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_dispatch_o,
  output logic [PERF_W-1:0]     perf_squash_o,
  output logic [PERF_W-1:0]     perf_stall_o
`endif
);

  dispatch_state_t state_q, state_d;
  core_mask_t      busy_q, busy_d;
  core_mask_t      spec2_q, spec2_d;
  core_id_t        rr_ptr_q, rr_ptr_d;
  core_id_t        serial_id_q, serial_id_d;
  core_mask_t      disp_valid_q;
  core_mask_t      flush_q;
  addr_t           disp_pc_q;
  logic [1:0]      disp_level_q;

  spec_level_t     blk_level;
  logic            serial_lvl;
  core_mask_t      pick_onehot;
  core_id_t        pick_idx;
  logic            any_free;
  logic            squash_hit;
  core_mask_t      squash_mask;
  logic            ready_c;
  logic            accept;
  core_mask_t      grant_onehot;

  assign blk_level  = spec_level_t'(blk_level_i);
  assign serial_lvl = is_serial_level(blk_level);

  // Candidate core from the registered busy vector
  stu_rr_picker u_picker (
    .free_i      (~busy_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (pick_onehot),
    .grant_idx_o (pick_idx),
    .any_free_o  (any_free)
  );

  // A fail only counts on a busy level-2 core; it then takes out every level-2 core
  always_comb begin
    squash_hit  = |(spec_fail_i & busy_q & spec2_q);
    squash_mask = squash_hit ? (busy_q & spec2_q) : '0;
  end

  // Next-state and acceptance decision; a squash overrides everything else
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    serial_id_d = serial_id_q;
    case (state_q)
      DISP_RUN: begin
        if (serial_lvl) begin
          ready_c = ~|busy_q;
          if (blk_valid_i) begin
            if (|busy_q) begin
              state_d = DISP_DRAIN;
            end else begin
              state_d     = DISP_SERIAL;
              serial_id_d = pick_idx;
            end
          end
        end else begin
          ready_c = any_free;
        end
      end
      DISP_DRAIN: begin
        if (~|busy_q) state_d = DISP_RUN;
      end
      DISP_SERIAL: begin
        if (core_done_i[serial_id_q]) state_d = DISP_RUN;
      end
      DISP_FLUSH: begin
        state_d = DISP_RUN;
      end
      default: begin
        state_d = DISP_RUN;
      end
    endcase
    if (squash_hit) begin
      state_d     = DISP_FLUSH;
      ready_c     = 1'b0;
      serial_id_d = serial_id_q;
    end
  end

  assign blk_ready_o = ready_c & ~rst;
  assign accept      = blk_valid_i & blk_ready_o;

  // Per-core bookkeeping; grants only target cores free in the registered vector
  always_comb begin
    grant_onehot = accept ? pick_onehot : '0;
    busy_d       = (busy_q & ~core_done_i & ~squash_mask) | grant_onehot;
    spec2_d      = (spec2_q & ~core_done_i & ~squash_mask)
                 | ((blk_level == SPEC_LEVEL_2) ? grant_onehot : '0);
    rr_ptr_d     = accept ? core_id_t'(pick_idx + core_id_t'(1)) : rr_ptr_q;
  end

  // State, per-core flags and registered dispatch/flush outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DISP_RUN;
      busy_q       <= '0;
      spec2_q      <= '0;
      rr_ptr_q     <= '0;
      serial_id_q  <= '0;
      disp_valid_q <= '0;
      flush_q      <= '0;
      disp_pc_q    <= '0;
      disp_level_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      spec2_q      <= spec2_d;
      rr_ptr_q     <= rr_ptr_d;
      serial_id_q  <= serial_id_d;
      disp_valid_q <= grant_onehot;
      flush_q      <= squash_mask;
      if (accept) begin
        disp_pc_q    <= blk_pc_i;
        disp_level_q <= blk_level_i;
      end
    end
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_pc_o    = disp_pc_q;
  assign disp_level_o = disp_level_q;
  assign flush_o      = flush_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;

`ifdef STU_DISPATCH_PERF_EN
  logic [PERF_W-1:0] perf_dispatch_q;
  logic [PERF_W-1:0] perf_squash_q;
  logic [PERF_W-1:0] perf_stall_q;
  logic              stall;

  assign stall = blk_valid_i & ~blk_ready_o;

  // Saturating event counters: accepted blocks, squash events, stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatch_q <= '0;
      perf_squash_q   <= '0;
      perf_stall_q    <= '0;
    end else begin
      if (accept && !(&perf_dispatch_q))  perf_dispatch_q <= perf_dispatch_q + PERF_W'(1);
      if (squash_hit && !(&perf_squash_q)) perf_squash_q  <= perf_squash_q + PERF_W'(1);
      if (stall && !(&perf_stall_q))       perf_stall_q   <= perf_stall_q + PERF_W'(1);
    end
  end

  assign perf_dispatch_o = perf_dispatch_q;
  assign perf_squash_o   = perf_squash_q;
  assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_stu_block_dispatcher.sv
// Self-checking bench for stu_block_dispatcher: directed scenarios plus a
// randomized run against a behavioural scheduling model.
module tb_stu_block_dispatcher;
  import stu_pkg::*;

  localparam int NC = int'(NUM_CORES);

  logic                  clk;
  logic                  rst;
  logic                  blk_valid_i;
  logic                  blk_ready_o;
  logic [ADDR_WIDTH-1:0] blk_pc_i;
  logic [1:0]            blk_level_i;
  logic [NUM_CORES-1:0]  disp_valid_o;
  logic [ADDR_WIDTH-1:0] disp_pc_o;
  logic [1:0]            disp_level_o;
  logic [NUM_CORES-1:0]  core_done_i;
  logic [NUM_CORES-1:0]  spec_fail_i;
  logic [NUM_CORES-1:0]  flush_o;
  logic [NUM_CORES-1:0]  busy_o;
  logic [1:0]            state_o;
`ifdef STU_DISPATCH_PERF_EN
  logic [31:0]           perf_dispatch_o;
  logic [31:0]           perf_squash_o;
  logic [31:0]           perf_stall_o;
`endif

  int total = 0;
  int bad   = 0;

  stu_block_dispatcher dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid_i  (blk_valid_i),
    .blk_ready_o  (blk_ready_o),
    .blk_pc_i     (blk_pc_i),
    .blk_level_i  (blk_level_i),
    .disp_valid_o (disp_valid_o),
    .disp_pc_o    (disp_pc_o),
    .disp_level_o (disp_level_o),
    .core_done_i  (core_done_i),
    .spec_fail_i  (spec_fail_i),
    .flush_o      (flush_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
`ifdef STU_DISPATCH_PERF_EN
    ,
    .perf_dispatch_o (perf_dispatch_o),
    .perf_squash_o   (perf_squash_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [1:0] lvl,
                        input logic [3:0] done, input logic [3:0] fail);
    blk_valid_i = v;
    blk_pc_i    = pc;
    blk_level_i = lvl;
    core_done_i = done;
    spec_fail_i = fail;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 64'h1000, 2'd1, 4'b0, 4'b0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", blk_ready_o); end
    total++; if (busy_o !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b exp=0000", busy_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (disp_valid_o !== 4'b0) begin bad++; $display("FAIL reset_disp got=%b exp=0000", disp_valid_o); end
    total++; if (flush_o !== 4'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0000", flush_o); end
    total++; if (disp_pc_o !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", disp_pc_o); end
`ifdef STU_DISPATCH_PERF_EN
    total++; if (perf_dispatch_o !== 32'd0) begin bad++; $display("FAIL reset_perf_disp got=%0d exp=0", perf_dispatch_o); end
`endif
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_release_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 64'h1000 + 64'(k) * 64'h40, 2'd1, 4'b0, 4'b0);
      #1;
      total++; if (blk_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, blk_ready_o); end
      @(negedge clk);
      total++; if (disp_valid_o !== 4'(1 << k)) begin bad++; $display("FAIL b2b_disp%0d got=%b exp=%b", k, disp_valid_o, 4'(1 << k)); end
      total++; if (disp_pc_o !== 64'h1000 + 64'(k) * 64'h40) begin bad++; $display("FAIL b2b_pc%0d got=%h", k, disp_pc_o); end
      total++; if (disp_level_o !== 2'd1) begin bad++; $display("FAIL b2b_lvl%0d got=%0d exp=1", k, disp_level_o); end
    end
    set_in(1'b1, 64'h1100, 2'd1, 4'b0, 4'b0);
    #1;
    total++; if (busy_o !== 4'b1111) begin bad++; $display("FAIL b2b_busy got=%b exp=1111", busy_o); end
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (disp_valid_o !== 4'b0) begin bad++; $display("FAIL b2b_nodisp got=%b exp=0000", disp_valid_o); end
`ifdef STU_DISPATCH_PERF_EN
    total++; if (perf_dispatch_o !== 32'd4) begin bad++; $display("FAIL b2b_perf_disp got=%0d exp=4", perf_dispatch_o); end
    total++; if (perf_stall_o !== 32'd1) begin bad++; $display("FAIL b2b_perf_stall got=%0d exp=1", perf_stall_o); end
`endif
    set_in(1'b0, 64'h0, 2'd0, 4'b1111, 4'b0);
    @(negedge clk);
    total++; if (busy_o !== 4'b0000) begin bad++; $display("FAIL b2b_done got=%b exp=0000", busy_o); end
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
  endtask

  task automatic test_level0_drain();
    set_in(1'b1, 64'h3000, 2'd1, 4'b0, 4'b0); @(negedge clk);
    set_in(1'b1, 64'h3040, 2'd1, 4'b0, 4'b0); @(negedge clk);
    total++; if (busy_o !== 4'b0011) begin bad++; $display("FAIL drain_setup got=%b exp=0011", busy_o); end
    set_in(1'b1, 64'h2000, 2'd0, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL drain_ready0 got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL drain_state got=%0d exp=1", state_o); end
    set_in(1'b1, 64'h2000, 2'd0, 4'b0011, 4'b0);
    @(negedge clk);
    total++; if (busy_o !== 4'b0000) begin bad++; $display("FAIL drain_busy got=%b exp=0000", busy_o); end
    set_in(1'b1, 64'h2000, 2'd0, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL drain_ready1 got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL drain_run got=%0d exp=0", state_o); end
    #1;
    total++; if (blk_ready_o !== 1'b1) begin bad++; $display("FAIL drain_accept got=%b exp=1", blk_ready_o); end
    @(negedge clk);
    total++; if (disp_valid_o !== 4'b0100) begin bad++; $display("FAIL serial_disp got=%b exp=0100", disp_valid_o); end
    total++; if (disp_level_o !== 2'd0) begin bad++; $display("FAIL serial_lvl got=%0d exp=0", disp_level_o); end
    total++; if (disp_pc_o !== 64'h2000) begin bad++; $display("FAIL serial_pc got=%h exp=2000", disp_pc_o); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL serial_state got=%0d exp=2", state_o); end
    set_in(1'b1, 64'h3080, 2'd1, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL serial_stall got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    set_in(1'b1, 64'h3080, 2'd1, 4'b0100, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL serial_stall2 got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL serial_end got=%0d exp=0", state_o); end
    set_in(1'b1, 64'h3080, 2'd1, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b1) begin bad++; $display("FAIL post_serial_ready got=%b exp=1", blk_ready_o); end
    @(negedge clk);
    total++; if (disp_valid_o !== 4'b1000) begin bad++; $display("FAIL post_serial_disp got=%b exp=1000", disp_valid_o); end
    set_in(1'b0, 64'h0, 2'd0, 4'b1000, 4'b0);
    @(negedge clk);
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
  endtask

  task automatic test_squash();
    set_in(1'b1, 64'h4000, 2'd2, 4'b0, 4'b0); @(negedge clk);
    set_in(1'b1, 64'h4040, 2'd1, 4'b0, 4'b0); @(negedge clk);
    set_in(1'b1, 64'h4080, 2'd2, 4'b0, 4'b0); @(negedge clk);
    total++; if (busy_o !== 4'b0111) begin bad++; $display("FAIL squash_setup got=%b exp=0111", busy_o); end
    set_in(1'b1, 64'h40C0, 2'd1, 4'b0, 4'b0100);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL squash_ready got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (flush_o !== 4'b0101) begin bad++; $display("FAIL squash_flush got=%b exp=0101", flush_o); end
    total++; if (busy_o !== 4'b0010) begin bad++; $display("FAIL squash_busy got=%b exp=0010", busy_o); end
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL squash_state got=%0d exp=3", state_o); end
    total++; if (disp_valid_o !== 4'b0) begin bad++; $display("FAIL squash_nodisp got=%b exp=0000", disp_valid_o); end
    set_in(1'b1, 64'h40C0, 2'd1, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (flush_o !== 4'b0) begin bad++; $display("FAIL flush_pulse got=%b exp=0000", flush_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL flush_exit got=%0d exp=0", state_o); end
`ifdef STU_DISPATCH_PERF_EN
    total++; if (perf_squash_o !== 32'd1) begin bad++; $display("FAIL perf_squash got=%0d exp=1", perf_squash_o); end
`endif
    set_in(1'b1, 64'h40C0, 2'd1, 4'b0, 4'b0011);
    @(negedge clk);
    total++; if (flush_o !== 4'b0) begin bad++; $display("FAIL l1_fail_flush got=%b exp=0000", flush_o); end
    total++; if (busy_o !== 4'b1010) begin bad++; $display("FAIL l1_fail_busy got=%b exp=1010", busy_o); end
    total++; if (disp_valid_o !== 4'b1000) begin bad++; $display("FAIL l1_fail_disp got=%b exp=1000", disp_valid_o); end
    set_in(1'b0, 64'h0, 2'd0, 4'b1010, 4'b0);
    @(negedge clk);
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
  endtask

  task automatic test_bypass_and_reset_mid();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 64'h6000 + 64'(k), 2'd1, 4'b0, 4'b0);
      @(negedge clk);
    end
    set_in(1'b0, 64'h0, 2'd0, 4'b0111, 4'b0);
    @(negedge clk);
    total++; if (busy_o !== 4'b1000) begin bad++; $display("FAIL bypass_setup got=%b exp=1000", busy_o); end
    set_in(1'b1, 64'h7000, 2'b11, 4'b0, 4'b0);
    #1;
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL bypass_ready got=%b exp=0", blk_ready_o); end
    @(negedge clk);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL bypass_drain got=%0d exp=1", state_o); end
    set_in(1'b1, 64'h7000, 2'b11, 4'b1000, 4'b0); @(negedge clk);
    set_in(1'b1, 64'h7000, 2'b11, 4'b0, 4'b0);    @(negedge clk);
    #1;
    total++; if (blk_ready_o !== 1'b1) begin bad++; $display("FAIL bypass_accept got=%b exp=1", blk_ready_o); end
    @(negedge clk);
    total++; if (disp_valid_o !== 4'b0001) begin bad++; $display("FAIL bypass_disp got=%b exp=0001", disp_valid_o); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL bypass_serial got=%0d exp=2", state_o); end
    total++; if (busy_o !== 4'b0001) begin bad++; $display("FAIL bypass_busy got=%b exp=0001", busy_o); end
    set_in(1'b1, 64'h5000, 2'd1, 4'b0, 4'b0);
    #3;
    rst = 1'b1;
    #1;
    total++; if (busy_o !== 4'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0000", busy_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", state_o); end
    total++; if (disp_valid_o !== 4'b0) begin bad++; $display("FAIL rstmid_disp got=%b exp=0000", disp_valid_o); end
    total++; if (disp_pc_o !== 64'h0) begin bad++; $display("FAIL rstmid_pc got=%h exp=0", disp_pc_o); end
    total++; if (disp_level_o !== 2'd0) begin bad++; $display("FAIL rstmid_lvl got=%0d exp=0", disp_level_o); end
    total++; if (blk_ready_o !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", blk_ready_o); end
`ifdef STU_DISPATCH_PERF_EN
    total++; if (perf_dispatch_o !== 32'd0) begin bad++; $display("FAIL rstmid_perf_disp got=%0d exp=0", perf_dispatch_o); end
    total++; if (perf_squash_o !== 32'd0) begin bad++; $display("FAIL rstmid_perf_sq got=%0d exp=0", perf_squash_o); end
    total++; if (perf_stall_o !== 32'd0) begin bad++; $display("FAIL rstmid_perf_stall got=%0d exp=0", perf_stall_o); end
`endif
    @(negedge clk);
    total++; if (flush_o !== 4'b0) begin bad++; $display("FAIL rstmid_flush got=%b exp=0000", flush_o); end
    rst = 1'b0;
    #1;
    total++; if (blk_ready_o !== 1'b1) begin bad++; $display("FAIL rstrel_ready got=%b exp=1", blk_ready_o); end
    @(negedge clk);
    total++; if (disp_valid_o !== 4'b0001) begin bad++; $display("FAIL rstrel_disp got=%b exp=0001", disp_valid_o); end
    total++; if (disp_pc_o !== 64'h5000) begin bad++; $display("FAIL rstrel_pc got=%h exp=5000", disp_pc_o); end
    set_in(1'b0, 64'h0, 2'd0, 4'b0001, 4'b0);
    @(negedge clk);
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
  endtask

  // Random traffic against a scheduling model written from the policy rules
  task automatic test_random();
    bit          mbusy[NC];
    bit          mlvl2[NC];
    int          mrr, mstate, mserial;
    logic        holding;
    logic [63:0] hpc;
    logic [1:0]  hlvl;
    logic [3:0]  done, fail, e_disp, e_flush;
    logic [63:0] e_pc;
    logic [1:0]  e_lvl;
    bit          squash, any_busy, all_busy, lvl0, exp_ready, acc;
    int          g, r;

    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin mbusy[i] = 1'b0; mlvl2[i] = 1'b0; end
    mrr = 0; mstate = 0; mserial = 0; holding = 1'b0; hpc = '0; hlvl = '0;
    e_pc = '0; e_lvl = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!holding && $urandom_range(0, 9) < 6) begin
        holding = 1'b1;
        hpc = {$urandom, $urandom};
        r = int'($urandom_range(0, 9));
        hlvl = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      end
      done = '0;
      for (int i = 0; i < NC; i++) if ($urandom_range(0, 3) == 0) done[i] = 1'b1;
      fail = '0;
      if ($urandom_range(0, 7) == 0) fail[$urandom_range(0, 3)] = 1'b1;
      set_in(holding, holding ? hpc : 64'h0, holding ? hlvl : 2'd0, done, fail);

      squash = 1'b0; any_busy = 1'b0; all_busy = 1'b1;
      for (int i = 0; i < NC; i++) begin
        if (fail[i] && mbusy[i] && mlvl2[i]) squash = 1'b1;
        if (mbusy[i]) any_busy = 1'b1; else all_busy = 1'b0;
      end
      lvl0      = (hlvl == 2'd0) || (hlvl == 2'd3);
      exp_ready = (mstate == 0) && !squash && (lvl0 ? !any_busy : !all_busy);
      acc       = holding && exp_ready;

      #1;
      if (holding) begin
        total++;
        if (blk_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, blk_ready_o, exp_ready); end
      end

      g = -1;
      if (acc) begin
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (mrr + k) % NC;
          if (g < 0 && !mbusy[c]) g = c;
        end
      end
      e_flush = '0;
      if (squash) for (int i = 0; i < NC; i++) if (mbusy[i] && mlvl2[i]) e_flush[i] = 1'b1;

      if (squash) mstate = 3;
      else begin
        case (mstate)
          0: if (acc && lvl0) begin mstate = 2; mserial = g; end
             else if (holding && lvl0 && any_busy) mstate = 1;
          1: if (!any_busy) mstate = 0;
          2: if (done[mserial]) mstate = 0;
          default: mstate = 0;
        endcase
      end
      for (int i = 0; i < NC; i++) if (e_flush[i] || done[i]) begin mbusy[i] = 1'b0; mlvl2[i] = 1'b0; end
      e_disp = '0;
      if (g >= 0) begin
        mbusy[g] = 1'b1;
        mlvl2[g] = (hlvl == 2'd2);
        mrr      = (g + 1) % NC;
        e_disp[g] = 1'b1;
        e_pc  = hpc;
        e_lvl = hlvl;
      end

      @(negedge clk);
      total++;
      if (busy_o !== {mbusy[3], mbusy[2], mbusy[1], mbusy[0]}) begin
        bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, {mbusy[3], mbusy[2], mbusy[1], mbusy[0]});
      end
      total++; if (state_o !== 2'(mstate)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, state_o, mstate); end
      total++; if (disp_valid_o !== e_disp) begin bad++; $display("FAIL rnd_disp cyc=%0d got=%b exp=%b", cyc, disp_valid_o, e_disp); end
      total++; if (flush_o !== e_flush) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, flush_o, e_flush); end
      if (e_disp != 4'b0) begin
        total++; if (disp_pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, disp_pc_o, e_pc); end
        total++; if (disp_level_o !== e_lvl) begin bad++; $display("FAIL rnd_lvl cyc=%0d got=%0d exp=%0d", cyc, disp_level_o, e_lvl); end
      end
      if (acc) holding = 1'b0;
    end
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 64'h0, 2'd0, 4'b0, 4'b0);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_level0_drain();
    test_squash();
    test_bypass_and_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stu_block_dispatcher.md
Name: stu_block_dispatcher

Overview:
- Scheduler in front of the STU core cluster. Accepts speculative code-block descriptors (start PC plus spec level) and issues them to free cores round-robin.
- Enforces the adaptive policy:
  - Level 0 serializes: the block runs alone on an otherwise idle cluster.
  - Levels 1 and 2 run in parallel.
  - A level-2 misspeculation squashes every in-flight level-2 block.

Parameters:
- NUM_CORES, stu_pkg::NUM_CORES (4): number of cores scheduled; power of two, ≥2.
- ADDR_WIDTH, stu_pkg::ADDR_WIDTH (64): PC width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- blk_valid_i  in  1  descriptor valid.
- blk_ready_o  out  1  descriptor accepted when valid&ready.
- blk_pc_i  in  ADDR_WIDTH  block start PC.
- blk_level_i  in  2  spec_level_t.
- disp_valid_o  out  NUM_CORES  one-hot, one-cycle dispatch pulse per core.
- disp_pc_o  out  ADDR_WIDTH  PC of dispatched block.
- disp_level_o  out  2  level of dispatched block.
- core_done_i  in  NUM_CORES  per-core block-complete pulse.
- spec_fail_i  in  NUM_CORES  per-core misspeculation pulse.
- flush_o  out  NUM_CORES  one-cycle squash pulse, per core.
- busy_o  out  NUM_CORES  registered busy vector.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (async, rst=1): state RUN; busy_o, spec2 flags, disp_valid_o, flush_o, disp_pc_o, disp_level_o all 0; rr pointer 0; blk_ready_o 0 while rst is high.
- Level encoding 2'b11 is treated as SPEC_LEVEL_0_BYPASS.
- Per-core state is a busy bit plus an is_spec2 bit.
- States: RUN=0, DRAIN=1, SERIAL=2, FLUSH=3.
- RUN, level 1/2 presented:
  - blk_ready_o = (busy_o != all-ones), combinational.
  - On accept, the grant goes to the first free core at or after rr_ptr, with wrap-around. rr_ptr becomes grant+1 mod NUM_CORES.
  - disp_valid_o/pc/level are registered: the pulse appears the cycle after the handshake (latency 1).
  - busy[g] and is_spec2[g] are set in that same edge.
- RUN, level 0 presented:
  - blk_ready_o = (busy_o == 0).
  - If any core is busy: blk_ready_o=0 and the FSM goes to DRAIN.
  - If all cores are idle: accept, grant per rr, go to SERIAL.
- DRAIN:
  - blk_ready_o=0; no dispatch.
  - When busy_o==0, go to RUN. The held level-0 descriptor is then accepted on the next cycle.
  - Holding the descriptor is required by valid/ready: the source must keep valid, pc and level stable until accepted.
- SERIAL:
  - blk_ready_o=0.
  - core_done_i on the serial core → RUN.
- Busy update each edge: busy_next = (busy & ~core_done_i & ~squash_mask) | grant_onehot.
  - Free-core selection uses the registered busy, so a done and a new grant never target the same core in one cycle.
  - core_done_i on an idle core is ignored.
- Misspeculation:
  - Any spec_fail_i bit on a busy core with is_spec2=1 sets squash_mask = busy & is_spec2 (all level-2 cores). Those cores clear busy/is_spec2 that edge.
  - flush_o = squash_mask, registered, 1-cycle pulse. FSM enters FLUSH for exactly 1 cycle with blk_ready_o=0, then returns to RUN.
  - spec_fail_i on a non-level-2 or idle core is ignored.
  - If spec_fail_i and core_done_i hit the same core in one cycle, the squash wins (flush_o includes that core).
- Level-1 cores are never flushed.
- Simultaneous accept and valid squash in RUN: the squash takes priority and blk_ready_o is forced 0 that cycle (combinationally from spec_fail_i).
- Reset mid-operation: everything returns to reset values immediately. In-flight blocks are forgotten; no flush_o is emitted.

Optional Feature:
- Macro: STU_DISPATCH_PERF_EN.
- Defined: adds outputs perf_dispatch_o, perf_squash_o and perf_stall_o, each 32-bit, saturating at 2^32-1, reset to 0.
  - perf_dispatch_o counts accepted blocks.
  - perf_squash_o counts squash events, not cores.
  - perf_stall_o counts cycles with blk_valid_i=1 and blk_ready_o=0.
- Undefined: ports absent, no counter logic.

Decomposition:
- stu_pkg additions:
  - dispatch_state_t enum {DISP_RUN, DISP_DRAIN, DISP_SERIAL, DISP_FLUSH}.
  - core_mask_t = logic [NUM_CORES-1:0].
  - Reuse existing addr_t, core_id_t, spec_level_t.
- One sub-module: stu_rr_picker (combinational).
  - Inputs: free mask, rr_ptr.
  - Outputs: one-hot grant, grant index, any_free.

Test Plan:
- Four level-1 blocks (PCs 0x1000, 0x1040, 0x1080, 0x10C0) back-to-back from reset:
  - disp_valid_o = 0001, 0010, 0100, 1000 on consecutive cycles.
  - busy_o = 1111, then blk_ready_o = 0.
- Cores 0 and 1 busy with level 1, then a level-0 block at 0x2000:
  - State DRAIN, ready=0.
  - After core_done_i = 0011, back to RUN; the block dispatches to the rr core with disp_level_o=0; state SERIAL.
  - A level-1 block is stalled until that core's done.
- Cores 0 and 2 level-2, core 1 level-1; spec_fail_i=0100:
  - Next cycle flush_o=0101, busy_o=0010, state FLUSH for 1 cycle, ready=0.
- spec_fail_i=0010 on level-1 core 1 → no flush_o, busy unchanged.
- blk_level_i=2'b11 with core 3 busy → DRAIN; with all idle → SERIAL dispatch.
- rst asserted mid-SERIAL with busy=0001:
  - Outputs zero asynchronously.
  - After release, the first level-1 block goes to core 0.
  - With STU_DISPATCH_PERF_EN, counters read 0.
